msg_char_sequencer: RTL

Parametrised ASCII message streamer for the Tiny Tapeout top level. It holds `NUM_MSGS` fixed text messages in a ROM and emits one selected message, character by character, over a valid/ready handshake. Each message has its own length. Inter-character gap, one-shot or loop mode, and abort are run-time controls. The downstream consumer is the `uo_out` driver, a UART or an LCD writer.

---
 rtl/msg_pkg.sv | 50 +++++
 rtl/msg_char_sequencer_if.sv | 14 +
 rtl/msg_char_sequencer_rom.sv | 25 ++
 rtl/msg_char_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message streamer: FSM encoding, message lengths and ROM text.
// Constants and pure lookup functions only; no storage, zero latency.
// No flow control here; callers own all handshaking.
package msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int ROM_MSGS    = 4;
  localparam int ROM_MAX_LEN = 16;
  localparam int ROM_SEL_W   = $clog2(ROM_MSGS);
  localparam int ROM_IDX_W   = $clog2(ROM_MAX_LEN);

  localparam int MSG_LEN [ROM_MSGS] = '{9, 7, 6, 13};

  // One byte per slot, zero-padded to ROM_MAX_LEN.
  localparam logic [7:0] MSG_ROM [ROM_MSGS][ROM_MAX_LEN] = '{
    // "Guatemala"
    '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C,
      8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Quetzal"
    '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Zacapa"
    '{8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Soy de Zacapa"
    '{8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65, 8'h20, 8'h5A,
      8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00, 8'h00}
  };

  // Length of message s; messages beyond the ROM are empty.
  function automatic int msg_len(input int s);
    if (s >= 0 && s < ROM_MSGS) return MSG_LEN[s[ROM_SEL_W-1:0]];
    return 0;
  endfunction

  // Character i of message s; anything outside the message reads as 0.
  function automatic logic [7:0] rom_char(input int s, input int i);
    if (s >= 0 && s < ROM_MSGS && i >= 0 && i < ROM_MAX_LEN &&
        i < MSG_LEN[s[ROM_SEL_W-1:0]])
      return MSG_ROM[s[ROM_SEL_W-1:0]][i[ROM_IDX_W-1:0]];
    return 8'h00;
  endfunction

endpackage

// File: rtl/msg_char_sequencer_if.sv
// Character stream bundle between the sequencer and its consumer.
// Wires only, zero latency.
// valid/ready: the master holds char_out/char_last until valid & ready at an edge.
interface msg_char_sequencer_if #(
  parameter int CHAR_W = 8
);
  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;

  modport master (output char_out, output char_valid, output char_last, input char_ready);
  modport slave  (input char_out, input char_valid, input char_last, output char_ready);
endinterface

// File: rtl/msg_char_sequencer_rom.sv
// Combinational (message, index) to character lookup over the shared ROM.
// Zero latency.
// No flow control; out-of-range message or index returns 0.
module msg_rom
  import msg_pkg::*;
#(
  parameter int NUM_MSGS = 4,
  parameter int MAX_LEN  = 16,
  parameter int CHAR_W   = 8,
  localparam int SEL_W   = $clog2(NUM_MSGS),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [LEN_W-1:0]  i_idx,
  output logic [CHAR_W-1:0] o_char
);

  // Look up the character, forcing 0 past the configured maximum length.
  always_comb begin
    o_char = '0;
    if (int'(i_idx) < MAX_LEN)
      o_char = CHAR_W'(rom_char(int'(i_sel), int'(i_idx)));
  end

endmodule

// File: rtl/msg_char_sequencer.sv
// Streams one ROM message character by character with optional gap, loop and abort.
// Start sampled at edge N shows char 0 after edge N; 1 char/cycle when gap is 0.
// Holds char_out/char_last until valid & ready; all outputs registered, no ready-to-output path.
module msg_char_sequencer
  import msg_pkg::*;
#(
  parameter int NUM_MSGS = 4,
  parameter int MAX_LEN  = 16,
  parameter int CHAR_W   = 8,
  parameter int GAP_W    = 8,
  localparam int SEL_W   = $clog2(NUM_MSGS),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 start,
  input  logic                 loop_en,
  input  logic                 abort,
  input  logic [GAP_W-1:0]     gap,
  msg_char_sequencer_if.master strm,
  output logic                 busy,
  output logic                 done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_e            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_idx, w_idx_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              r_loop, w_loop_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;

  logic [CHAR_W-1:0] r_char, w_char_nxt, w_rom_char;
  logic              r_valid, w_valid_nxt;
  logic              r_last, w_last_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [LEN_W-1:0]  w_len_nxt;
  logic              w_xfer;

  // Message length clipped to what the index counter can address.
  function automatic logic [LEN_W-1:0] len_of(input logic [SEL_W-1:0] s);
    int l;
    l = msg_len(int'(s));
    if (l > MAX_LEN) l = MAX_LEN;
    return LEN_W'(l);
  endfunction

  assign w_xfer = r_valid & strm.char_ready;

  // The ROM is addressed with next-cycle selection so the character can be registered.
  msg_rom #(
    .NUM_MSGS (NUM_MSGS),
    .MAX_LEN  (MAX_LEN),
    .CHAR_W   (CHAR_W)
  ) u_rom (
    .i_sel  (w_sel_nxt),
    .i_idx  (w_idx_nxt),
    .o_char (w_rom_char)
  );

  // State register plus index, gap counter and controls latched at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_sel     <= '0;
      r_loop    <= 1'b0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_loop    <= w_loop_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  // Next-state logic; abort overrides everything, including a same-cycle handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sel_nxt     = r_sel;
    w_loop_nxt    = r_loop;
    w_gap_nxt     = r_gap;
    if (abort) begin
      w_state_nxt   = ST_IDLE;
      w_idx_nxt     = '0;
      w_gap_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_sel_nxt     = sel;
            w_loop_nxt    = loop_en;
            w_gap_nxt     = gap;
            w_idx_nxt     = '0;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = (len_of(sel) == '0) ? ST_DONE : ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_xfer) begin
            if (r_last && !r_loop) begin
              w_state_nxt = ST_DONE;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_last ? '0 : r_idx + LEN_ONE;
              if (r_gap == '0) begin
                w_state_nxt = ST_EMIT;
              end else begin
                w_state_nxt   = ST_GAP;
                w_gap_cnt_nxt = r_gap;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt <= GAP_ONE) begin
            w_state_nxt   = ST_EMIT;
            w_gap_cnt_nxt = '0;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so every output comes straight off a flop.
  always_comb begin
    w_len_nxt   = len_of(w_sel_nxt);
    w_valid_nxt = (w_state_nxt == ST_EMIT);
    w_char_nxt  = w_valid_nxt ? w_rom_char : '0;
    w_last_nxt  = w_valid_nxt && ((w_idx_nxt + LEN_ONE) == w_len_nxt);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_char  <= w_char_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign strm.char_out   = r_char;
  assign strm.char_valid = r_valid;
  assign strm.char_last  = r_last;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
